// File: rtl/msg_deser.sv
// Serial message deserializer: packs decoded bits MSB-first into words
// and queues them with bit count and end-of-message tag in a show-ahead FIFO.
module msg_deser #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     bin_msg,
  input  logic                     msg_rdy,
  input  logic                     msg_done,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DATA_W):0]  dout_nbits,
  output logic                     dout_last,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int CW = $clog2(DATA_W);
  localparam int NW = CW + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] TOP = CW'(DATA_W - 1);

  logic [DATA_W-1:0] pack, pk_n;
  logic [CW-1:0]     cnt, idx;
  logic [NW-1:0]     cnt_n;
  logic              push;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [NW-1:0]     mem_n [DEPTH];
  logic              mem_l [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       occ, occ_n;
  logic              pop, wr, ovf_set;

  // Bits land directly at their MSB-aligned slot, so a partial word
  // needs no shifting on flush and unused LSBs stay zero.
  always_comb begin
    pk_n  = pack;
    cnt_n = {1'b0, cnt};
    idx   = TOP - cnt;
    if (msg_rdy) begin
      pk_n[idx] = bin_msg;
      cnt_n     = cnt_n + 1'b1;
    end
    push = msg_done || (cnt_n == NW'(DATA_W));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pack <= '0;
      cnt  <= '0;
    end else if (push) begin
      pack <= '0;
      cnt  <= '0;
    end else begin
      pack <= pk_n;
      cnt  <= cnt_n[CW-1:0];
    end
  end

  assign pop     = rd_en && !empty;
  assign wr      = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    occ_n = occ;
    unique case ({wr, pop})
      2'b10:   occ_n = occ + 1'b1;
      2'b01:   occ_n = occ - 1'b1;
      default: occ_n = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_d[wptr] <= pk_n;
      mem_n[wptr] <= cnt_n;
      mem_l[wptr] <= msg_done;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      occ      <= occ_n;
      empty    <= (occ_n == '0);
      full     <= (occ_n == (PW+1)'(DEPTH));
      overflow <= overflow || ovf_set;
    end
  end

  assign dout       = empty ? '0 : mem_d[rptr];
  assign dout_nbits = empty ? '0 : mem_n[rptr];
  assign dout_last  = empty ? 1'b0 : mem_l[rptr];

endmodule

// File: tb/tb_msg_deser.sv
// Directed bench for msg_deser: packing, flush, marker, overflow,
// full-with-pop and mid-message reset.
module tb_msg_deser;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       bin_msg, msg_rdy, msg_done, rd_en;
  logic [7:0] dout;
  logic [3:0] dout_nbits;
  logic       dout_last, empty, full, overflow;

  int n_chk  = 0;
  int n_fail = 0;

  msg_deser #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_b(rst_b), .bin_msg(bin_msg), .msg_rdy(msg_rdy),
    .msg_done(msg_done), .rd_en(rd_en), .dout(dout),
    .dout_nbits(dout_nbits), .dout_last(dout_last), .empty(empty),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge; returns at the next negedge.
  task automatic cyc(input logic b, input logic rdy,
                     input logic done, input logic rd);
    bin_msg  = b;
    msg_rdy  = rdy;
    msg_done = done;
    rd_en    = rd;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] w, input logic done,
                           input logic rd);
    for (int i = 7; i >= 0; i--)
      cyc(w[i], 1'b1, done && (i == 0), rd && (i == 0));
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] d,
                         input logic [3:0] nb, input logic l);
    chk({tag, "_ne"}, 32'(empty), 32'd0);
    chk({tag, "_d"}, 32'(dout), 32'(d));
    chk({tag, "_nb"}, 32'(dout_nbits), 32'(nb));
    chk({tag, "_l"}, 32'(dout_last), 32'(l));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [15:0] w16;
  logic [10:0] b11;

  initial begin
    rst_b = 1'b0;
    bin_msg = 1'b0; msg_rdy = 1'b0; msg_done = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_nb", 32'(dout_nbits), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    rst_b = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // full-word message 0xA5C3, done on the 16th bit
    w16 = 16'hA5C3;
    for (int i = 15; i >= 8; i--)
      cyc(w16[i], 1'b1, 1'b0, 1'b0);
    chk("fw_lat_empty", 32'(empty), 32'd0);
    chk("fw_lat_head", 32'(dout), 32'hA5);
    for (int i = 7; i >= 0; i--)
      cyc(w16[i], 1'b1, i == 0, 1'b0);
    chk("fw_full", 32'(full), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    pop_chk("fw0", 8'hA5, 4'd8, 1'b0);
    pop_chk("fw1", 8'hC3, 4'd8, 1'b1);
    chk("fw_empty", 32'(empty), 32'd1);

    // partial message 1011_0011_101 then lone msg_done
    b11 = 11'b1011_0011_101;
    for (int i = 10; i >= 0; i--)
      cyc(b11[i], 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    pop_chk("pm0", 8'hB3, 4'd8, 1'b0);
    pop_chk("pm1", 8'hA0, 4'd3, 1'b1);

    // msg_done together with the last bit of a partial word
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    pop_chk("pd0", 8'hC0, 4'd3, 1'b1);
    chk("pd_empty", 32'(empty), 32'd1);

    // marker: 0xFF then msg_done one cycle later
    send_byte(8'hFF, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    pop_chk("mk0", 8'hFF, 4'd8, 1'b0);
    pop_chk("mk1", 8'h00, 4'd0, 1'b1);

    // overflow: 5 words, no reads
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    chk("ov_full", 32'(full), 32'd1);
    chk("ov_pre", 32'(overflow), 32'd0);
    send_byte(8'h55, 1'b0, 1'b0);
    chk("ov_set", 32'(overflow), 32'd1);
    chk("ov_full2", 32'(full), 32'd1);
    pop_chk("ov0", 8'h11, 4'd8, 1'b0);
    pop_chk("ov1", 8'h22, 4'd8, 1'b0);
    pop_chk("ov2", 8'h33, 4'd8, 1'b0);
    pop_chk("ov3", 8'h44, 4'd8, 1'b0);
    chk("ov_empty", 32'(empty), 32'd1);
    chk("ov_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("ov_clr", 32'(overflow), 32'd0);

    // full with simultaneous pop as a word completes
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    chk("fp_full0", 32'(full), 32'd1);
    send_byte(8'h5A, 1'b0, 1'b1);
    chk("fp_full1", 32'(full), 32'd1);
    chk("fp_ovf", 32'(overflow), 32'd0);
    pop_chk("fp0", 8'h02, 4'd8, 1'b0);
    pop_chk("fp1", 8'h03, 4'd8, 1'b0);
    pop_chk("fp2", 8'h04, 4'd8, 1'b0);
    pop_chk("fp3", 8'h5A, 4'd8, 1'b0);
    chk("fp_empty", 32'(empty), 32'd1);

    // reset after 5 bits of a message, then 0x3C with msg_done
    send_byte(8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("mr_empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mr_rd_empty", 32'(empty), 32'd1);
    send_byte(8'h3C, 1'b1, 1'b0);
    pop_chk("mr0", 8'h3C, 4'd8, 1'b1);
    chk("mr_end", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
